mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_pick.sv | 19 +
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port slow-memory arbiter.
package mem_arbiter_pkg;

   localparam int WORD         = 16;
   localparam int CNT_W        = 5;
   localparam int MEMDELAY_DEF = 4;
   localparam int TIMEOUT_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: one-hot grant, favouring the port not served last.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // Single requester wins outright; on contention the other port from 'last' wins
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port (0) and a data port (1) onto one slow
// memory, one transaction at a time, with a read timeout. All outputs registered.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEMDELAY = MEMDELAY_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      req,
   input  logic            p0_rnotw,
   input  logic            p1_rnotw,
   input  logic [WORD-1:0] p0_addr,
   input  logic [WORD-1:0] p1_addr,
   input  logic [WORD-1:0] p0_wdata,
   input  logic [WORD-1:0] p1_wdata,
   output logic [1:0]      grant,
   output logic [1:0]      done,
   output logic [WORD-1:0] rdata,
   output logic            err,
   output logic            busy,
   output logic            mem_strobe,
   output logic            mem_rnotw,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic            mem_mfc,
   input  logic [WORD-1:0] mem_rdata
);

   // Last WAIT count before a read is given up; WAIT lasts TIMEOUT cycles at most.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LAT_MIN  = CNT_W'(MEMDELAY);

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              port, port_d;
   logic              last, last_d;
   logic [1:0]        pick, port_oh;
   logic [1:0]        grant_d, done_d;
   logic [WORD-1:0]   rdata_d, addr_d, wdata_d;
   logic              err_d, busy_d, strobe_d, rnotw_d;

   rr_pick2 u_pick (
      .req   (req),
      .last  (last),
      .grant (pick)
   );

   assign port_oh = port ? 2'b10 : 2'b01;

   // Next-state and next-output decode; mem_rnotw/mem_addr/mem_wdata double as the request latch
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      port_d   = port;
      last_d   = last;
      grant_d  = 2'b00;
      done_d   = 2'b00;
      strobe_d = 1'b0;
      rdata_d  = rdata;
      err_d    = err;
      rnotw_d  = mem_rnotw;
      addr_d   = mem_addr;
      wdata_d  = mem_wdata;
      busy_d   = 1'b0;
      case (state)
         IDLE: begin
            if (pick != 2'b00) begin
               port_d   = pick[1];
               grant_d  = pick;
               strobe_d = 1'b1;
               rnotw_d  = pick[1] ? p1_rnotw : p0_rnotw;
               addr_d   = pick[1] ? p1_addr  : p0_addr;
               wdata_d  = pick[1] ? p1_wdata : p0_wdata;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = '0;
            if (mem_rnotw) begin
               state_d = WAIT;
            end else begin
               done_d  = port_oh;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         WAIT: begin
            if (mem_mfc) begin
               done_d  = port_oh;
               rdata_d = mem_rdata;
               err_d   = 1'b0;
               state_d = DONE;
            end else if (cnt == CNT_LAST) begin
               done_d  = port_oh;
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            last_d  = port;
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         port       <= 1'b0;
         last       <= 1'b1;
         grant      <= 2'b00;
         done       <= 2'b00;
         rdata      <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         mem_strobe <= 1'b0;
         mem_rnotw  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         port       <= port_d;
         last       <= last_d;
         grant      <= grant_d;
         done       <= done_d;
         rdata      <= rdata_d;
         err        <= err_d;
         busy       <= busy_d;
         mem_strobe <= strobe_d;
         mem_rnotw  <= rnotw_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
      end
   end

   // A read completion must not arrive sooner than the nominal memory latency
   a_mfc_latency : assert property (@(posedge clk) disable iff (!reset)
      (state == WAIT && mem_mfc) |-> (cnt >= LAT_MIN));

endmodule
